// File: rtl/aha_ahb_par_pkg.sv
// Shared types, AHB encodings and transfer-shape helpers for the AHB to
// parallel register-interface bridge.
package aha_ahb_par_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_ERR1,
        ST_ERR2
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Legal when the transfer fits the bus and the address is size-aligned.
    function automatic logic size_legal(input logic [2:0] hsize,
                                        input logic [2:0] addr_lsbs,
                                        input int         data_width);
        int nbytes;
        int off;
        nbytes = 1 << hsize;
        off    = int'(addr_lsbs);
        return ((8 * nbytes) <= data_width) && ((off & (nbytes - 1)) == 0);
    endfunction

    // Byte lanes touched by the transfer; bits above the bus width stay 0.
    function automatic logic [7:0] strb_gen(input logic [2:0] hsize,
                                            input logic [2:0] addr_lsbs,
                                            input int         data_width);
        logic [7:0] strb;
        int nbytes;
        int off;
        int bus_bytes;
        bus_bytes = data_width / 8;
        nbytes    = 1 << hsize;
        off       = int'(addr_lsbs) & (bus_bytes - 1);
        strb      = '0;
        for (int i = 0; i < 8; i++) begin
            strb[i] = (i < bus_bytes) && (i >= off) && (i < off + nbytes);
        end
        return strb;
    endfunction

endpackage

// File: rtl/aha_par_timeout_ctr.sv
// Data-phase timeout counter: cleared when an access starts, counts while the
// access is outstanding, expires on the cycle it would reach TIMEOUT_CYCLES.
module aha_par_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [15:0] LAST = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expire_o = 1'b0;
        end else begin : g_on
            assign expire_o = en_i && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/aha_ahb_par_bridge.sv
// AHB-Lite slave to Ordt parallel register bridge with registered response,
// ACK/NACK wait states, timeout and two-cycle ERROR responses.
//
// state     | meaning
// ST_IDLE   | ready, OKAY; accepts a new transfer
// ST_ACCESS | enable pulse issued, waiting for ACK/NACK or timeout
// ST_RESP   | last OKAY data-phase cycle; accepts a new transfer
// ST_ERR1   | first ERROR cycle, HREADYOUT low
// ST_ERR2   | second ERROR cycle, HREADYOUT high; accepts a new transfer
module aha_ahb_par_bridge
    import aha_ahb_par_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ERR_ON_NACK    = 1
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSEL,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    input  logic [2:0]                HSIZE,
    input  logic                      HREADYMUX,
    input  logic [31:0]               HADDR,
    input  logic [DATA_WIDTH-1:0]     HWDATA,
    input  logic [2:0]                HBURST,
    input  logic [3:0]                HPROT,
    input  logic [3:0]                HMASTER,
    input  logic                      HMASTLOCK,
    output logic [DATA_WIDTH-1:0]     HRDATA,
    output logic                      HREADYOUT,
    output logic [1:0]                HRESP,
    output logic [ADDR_WIDTH-1:0]     PAR_ADDR,
    output logic                      PAR_RD_EN,
    output logic                      PAR_WR_EN,
    output logic [DATA_WIDTH/8-1:0]   PAR_WR_STRB,
    output logic [DATA_WIDTH-1:0]     PAR_WR_DATA,
    input  logic [DATA_WIDTH-1:0]     PAR_RD_DATA,
    input  logic                      PAR_ACK,
    input  logic                      PAR_NACK,
    output logic                      TIMEOUT_EVT
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_e                  state_q;
    logic                    hready_q;
    logic [1:0]              hresp_q;
    logic [DATA_WIDTH-1:0]   hrdata_q;
    logic [ADDR_WIDTH-1:0]   par_addr_q;
    logic                    rd_en_q;
    logic                    wr_en_q;
    logic [STRB_W-1:0]       strb_q;
    logic                    write_q;
    logic                    timeout_evt_q;

    logic                    valid;
    logic                    legal;
    logic                    expire;
    logic [7:0]              strb_all;
    logic                    unused_ok;

    // hready_q is high exactly in the states that may take a new address phase.
    assign valid    = HSEL & HREADYMUX & HTRANS[1] & hready_q;
    assign legal    = size_legal(HSIZE, HADDR[2:0], DATA_WIDTH);
    assign strb_all = strb_gen(HSIZE, HADDR[2:0], DATA_WIDTH);

    assign unused_ok = ^{HBURST, HPROT, HMASTER, HMASTLOCK, HADDR, HTRANS[0], strb_all};

    aha_par_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_i    (HCLK),
        .rst_n_i  (HRESETn),
        .clr_i    (valid & legal),
        .en_i     (state_q == ST_ACCESS),
        .expire_o (expire)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= ST_IDLE;
            hready_q      <= 1'b1;
            hresp_q       <= HRESP_OKAY;
            hrdata_q      <= '0;
            par_addr_q    <= '0;
            rd_en_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            strb_q        <= '0;
            write_q       <= 1'b0;
            timeout_evt_q <= 1'b0;
        end else begin
            rd_en_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            timeout_evt_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RESP, ST_ERR2: begin
                    if (valid && legal) begin
                        state_q    <= ST_ACCESS;
                        hready_q   <= 1'b0;
                        hresp_q    <= HRESP_OKAY;
                        par_addr_q <= HADDR[ADDR_WIDTH-1:0];
                        strb_q     <= strb_all[STRB_W-1:0];
                        write_q    <= HWRITE;
                        rd_en_q    <= ~HWRITE;
                        wr_en_q    <= HWRITE;
                    end else if (valid) begin
                        state_q  <= ST_ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= HRESP_ERROR;
                    end else begin
                        state_q  <= ST_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= HRESP_OKAY;
                    end
                end
                ST_ACCESS: begin
                    // NACK takes priority over a simultaneous ACK.
                    if (PAR_NACK) begin
                        strb_q <= '0;
                        if (ERR_ON_NACK != 0) begin
                            state_q <= ST_ERR1;
                            hresp_q <= HRESP_ERROR;
                        end else begin
                            state_q  <= ST_RESP;
                            hready_q <= 1'b1;
                            hrdata_q <= '0;
                        end
                    end else if (PAR_ACK) begin
                        strb_q   <= '0;
                        state_q  <= ST_RESP;
                        hready_q <= 1'b1;
                        hrdata_q <= write_q ? '0 : PAR_RD_DATA;
                    end else if (expire) begin
                        strb_q        <= '0;
                        state_q       <= ST_ERR1;
                        hresp_q       <= HRESP_ERROR;
                        timeout_evt_q <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state_q  <= ST_ERR2;
                    hready_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign HRDATA      = hrdata_q;
    assign HREADYOUT   = hready_q;
    assign HRESP       = hresp_q;
    assign PAR_ADDR    = par_addr_q;
    assign PAR_RD_EN   = rd_en_q;
    assign PAR_WR_EN   = wr_en_q;
    assign PAR_WR_STRB = strb_q;
    assign PAR_WR_DATA = HWDATA;
    assign TIMEOUT_EVT = timeout_evt_q;

endmodule
